// File: rtl/tlc_multi_phase_if.sv
// Signal bundle between the multi-phase traffic light controller and its
// environment: demand inputs, lamp drivers, countdown display.
interface tlc_multi_phase_if #(
  parameter int unsigned N_PHASE = 4,
  parameter int unsigned TW      = 6
);
  localparam int unsigned PW = $clog2(N_PHASE);

  logic                   ped_req;
  logic [N_PHASE-1:0]     veh_det;
  logic [2*N_PHASE-1:0]   light;
  logic                   walk;
  logic [PW-1:0]          phase_idx;
  logic [TW-1:0]          timer_display;
  logic                   ped_pending;

  modport master (
    input  ped_req, veh_det,
    output light, walk, phase_idx, timer_display, ped_pending
  );

  modport slave (
    output ped_req, veh_det,
    input  light, walk, phase_idx, timer_display, ped_pending
  );
endinterface

// File: rtl/tlc_multi_phase.sv
// N-phase traffic light controller: green/yellow/all-red per phase, demand-based
// phase skipping, and a latched pedestrian request that shortens green and adds WALK.
module tlc_multi_phase #(
  parameter int unsigned N_PHASE   = 4,
  parameter int unsigned TW        = 6,
  parameter int unsigned GREEN_T   = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned PED_T     = 5,
  parameter int unsigned MIN_GREEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  tlc_multi_phase_if.master  bus
);
  localparam int unsigned PW = $clog2(N_PHASE);

  localparam logic [TW-1:0] GR_LD    = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] YEL_LD   = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_LD    = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] PED_LD   = TW'(PED_T - 1);
  localparam logic [TW-1:0] TRUNC_AT = TW'(GREEN_T - MIN_GREEN);
  localparam logic [2*N_PHASE-1:0] RST_LIGHT = (2*N_PHASE)'(2'b10);

  typedef enum logic [1:0] {GREEN, YELLOW, ALLRED, WALK} state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic                  ped_q, ped_d;
  logic [2*N_PHASE-1:0]  light_q, light_d;
  logic                  walk_q, walk_d;

  logic [PW-1:0]         next_phase;
  logic [PW-1:0]         cand;
  logic                  found;

  // First demanding phase after the current one; the current phase is tried last.
  always_comb begin
    next_phase = PW'((32'(phase_q) + 1) % N_PHASE);
    cand       = '0;
    found      = 1'b0;
    for (int unsigned k = 1; k <= N_PHASE; k++) begin
      cand = PW'((32'(phase_q) + k) % N_PHASE);
      if (!found && bus.veh_det[cand]) begin
        next_phase = cand;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q - TW'(1);
    phase_d = phase_q;
    ped_d   = ped_q;

    case (state_q)
      GREEN: begin
        if (timer_q == '0 || (ped_q && timer_q <= TRUNC_AT)) begin
          state_d = YELLOW;
          timer_d = YEL_LD;
        end
      end
      YELLOW: begin
        if (timer_q == '0) begin
          state_d = ALLRED;
          timer_d = AR_LD;
        end
      end
      ALLRED: begin
        if (timer_q == '0) begin
          if (ped_q) begin
            state_d = WALK;
            timer_d = PED_LD;
          end else begin
            state_d = GREEN;
            timer_d = GR_LD;
            phase_d = next_phase;
          end
        end
      end
      WALK: begin
        if (timer_q == '0) begin
          state_d = GREEN;
          timer_d = GR_LD;
          phase_d = next_phase;
        end
      end
    endcase

    // Entering WALK serves the request and wins over a simultaneous press.
    if (state_d == WALK && state_q != WALK) begin
      ped_d = 1'b0;
    end else if (state_q != WALK && bus.ped_req) begin
      ped_d = 1'b1;
    end

    light_d = '0;
    case (state_d)
      GREEN:   light_d[{phase_d, 1'b0} +: 2] = 2'b10;
      YELLOW:  light_d[{phase_d, 1'b0} +: 2] = 2'b01;
      default: light_d = '0;
    endcase
    walk_d = (state_d == WALK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GREEN;
      timer_q <= GR_LD;
      phase_q <= '0;
      ped_q   <= 1'b0;
      light_q <= RST_LIGHT;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      ped_q   <= ped_d;
      light_q <= light_d;
      walk_q  <= walk_d;
    end
  end

  assign bus.light         = light_q;
  assign bus.walk          = walk_q;
  assign bus.phase_idx     = phase_q;
  assign bus.timer_display = timer_q;
  assign bus.ped_pending   = ped_q;
endmodule

// File: tb/tb_tlc_multi_phase.sv
// Scoreboard bench for tlc_multi_phase: a cycle model queues expected outputs
// per driven cycle; directed checks cover the key timing points.
module tb_tlc_multi_phase;
  localparam int unsigned N = 4, G_T = 10, Y_T = 3, AR_T = 1, P_T = 5, MIN_G = 4;
  localparam int S_G = 0, S_Y = 1, S_R = 2, S_W = 3;
  localparam logic [63:0] RESET_V = 64'({8'b00000010, 1'b0, 2'd0, 6'd9, 1'b0});

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  tlc_multi_phase_if #(.N_PHASE(4), .TW(6)) ifa ();
  tlc_multi_phase_if #(.N_PHASE(3), .TW(4)) ifb ();

  tlc_multi_phase #(.N_PHASE(4), .TW(6), .GREEN_T(10), .YELLOW_T(3), .ALLRED_T(1),
                    .PED_T(5), .MIN_GREEN(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  tlc_multi_phase #(.N_PHASE(3), .TW(4), .GREEN_T(6), .YELLOW_T(3), .ALLRED_T(1),
                    .PED_T(5), .MIN_GREEN(6)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned edge_n = 0;
  logic [63:0] sb[$];

  int          m_st;
  int unsigned m_tmr, m_ph;
  bit          m_ped;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_a();
    return 64'({ifa.light, ifa.walk, ifa.phase_idx, ifa.timer_display, ifa.ped_pending});
  endfunction

  function automatic logic [63:0] pack_exp();
    logic [7:0] l;
    l = 8'h00;
    if (m_st == S_G) l = 8'(2) << (2 * m_ph);
    if (m_st == S_Y) l = 8'(1) << (2 * m_ph);
    return 64'({l, (m_st == S_W), 2'(m_ph), 6'(m_tmr), m_ped});
  endfunction

  function automatic int unsigned model_next(input logic [3:0] veh);
    for (int k = 1; k <= int'(N); k++) begin
      if (veh[(m_ph + k) % N]) return (m_ph + k) % N;
    end
    return (m_ph + 1) % N;
  endfunction

  task automatic model_reset();
    m_st = S_G; m_tmr = G_T - 1; m_ph = 0; m_ped = 0;
  endtask

  task automatic model_step(input bit ped, input logic [3:0] veh);
    bit was_walk, to_walk;
    was_walk = (m_st == S_W);
    to_walk  = 0;
    if (m_st == S_G && (m_tmr == 0 || (m_ped && m_tmr <= G_T - MIN_G))) begin
      m_st = S_Y; m_tmr = Y_T - 1;
    end else if (m_st == S_Y && m_tmr == 0) begin
      m_st = S_R; m_tmr = AR_T - 1;
    end else if (m_st == S_R && m_tmr == 0 && m_ped) begin
      m_st = S_W; m_tmr = P_T - 1; to_walk = 1;
    end else if ((m_st == S_R || m_st == S_W) && m_tmr == 0) begin
      m_st = S_G; m_tmr = G_T - 1; m_ph = model_next(veh);
    end else begin
      m_tmr = m_tmr - 1;
    end
    if (to_walk) m_ped = 0;
    else if (!was_walk && ped) m_ped = 1;
  endtask

  task automatic step(input bit ped, input logic [3:0] veh);
    ifa.ped_req = ped;
    ifa.veh_det = veh;
    model_step(ped, veh);
    sb.push_back(pack_exp());
    @(posedge clk);
    #1;
    edge_n++;
    if (sb.size() == 0) check_eq("sb_empty", 64'd1, 64'd0);
    else check_eq("cyc", pack_a(), sb.pop_front());
  endtask

  task automatic do_reset_a();
    rst = 1'b1;
    #1;
    check_eq("rst_hold", pack_a(), RESET_V);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    edge_n = 0;
    check_eq("rst_rel", pack_a(), RESET_V);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.ped_req = 1'b0;
    ifa.veh_det = 4'hF;
    ifb.ped_req = 1'b0;
    ifb.veh_det = 3'b111;
    model_reset();
    #12;
    check_eq("reset", pack_a(), RESET_V);
    rst = 1'b0;

    // All phases demanding: 14-cycle period, phase 1 green from edge 14.
    for (int e = 1; e <= 56; e++) begin
      step(1'b0, 4'hF);
      if (e == 10) check_eq("yel0", 64'({ifa.light, ifa.timer_display}), 64'({8'b00000001, 6'd2}));
      if (e % 14 == 0) check_eq("rr_seq", 64'({ifa.phase_idx, ifa.light}),
                                64'({2'((e / 14) % 4), 8'(2) << (2 * ((e / 14) % 4))}));
    end

    // Single-cycle pedestrian pulse in green cycle 2.
    do_reset_a();
    for (int e = 1; e <= 30; e++) begin
      step(e == 2, 4'hF);
      if (e == 3)  check_eq("ped_green4", 64'(ifa.light), 64'(8'b00000010));
      if (e == 4)  check_eq("ped_yel", 64'(ifa.light), 64'(8'b00000001));
      if (e == 8)  check_eq("walk_on", 64'({ifa.walk, ifa.light, ifa.ped_pending}), 64'({1'b1, 8'h00, 1'b0}));
      if (e == 13) check_eq("after_walk", 64'({ifa.walk, ifa.phase_idx, ifa.light}), 64'({1'b0, 2'd1, 8'b00001000}));
    end

    // Only phase 3 demanding: 0 -> 3, then 3 repeated.
    do_reset_a();
    for (int e = 1; e <= 30; e++) begin
      step(1'b0, 4'b1000);
      if (e == 14 || e == 28) check_eq("lone3", 64'({ifa.phase_idx, ifa.light}), 64'({2'd3, 8'b10000000}));
    end

    // No demand: plain round-robin.
    do_reset_a();
    for (int e = 1; e <= 56; e++) begin
      step(1'b0, 4'h0);
      if (e % 14 == 0) check_eq("nodemand", 64'(ifa.phase_idx), 64'((e / 14) % 4));
    end

    // Asynchronous reset between edges, mid-YELLOW of phase 2.
    do_reset_a();
    for (int i = 0; i < 100 && !(m_st == S_Y && m_ph == 2); i++) step(1'b0, 4'hF);
    check_eq("y2_reached", 64'(ifa.light), 64'(8'b00010000));
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_rst", pack_a(), RESET_V);

    // Pedestrian button held: every phase truncated, WALK after each.
    do_reset_a();
    for (int e = 1; e <= 60; e++) begin
      step(1'b1, 4'hF);
      if (e == 4)  check_eq("hold_yel", 64'(ifa.light), 64'(8'b00000001));
      if (e == 8)  check_eq("hold_walk", 64'({ifa.walk, ifa.ped_pending}), 64'({1'b1, 1'b0}));
      if (e == 13) check_eq("hold_exit", 64'({ifa.walk, ifa.ped_pending, ifa.phase_idx}), 64'({1'b0, 1'b0, 2'd1}));
      if (e == 14) check_eq("hold_relatch", 64'(ifa.ped_pending), 64'd1);
    end

    // Random demand and sparse button presses.
    do_reset_a();
    for (int e = 1; e <= 300; e++) begin
      step($urandom_range(7) == 0, 4'($urandom));
    end

    // Reduced configuration: MIN_GREEN == GREEN_T gives no truncation; wrap 2 -> 0.
    rst = 1'b1;
    ifb.ped_req = 1'b1;
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    check_eq("b_reset", 64'({ifb.light, ifb.timer_display, ifb.phase_idx}), 64'({6'b000010, 4'd5, 2'd0}));
    for (int e = 1; e <= 46; e++) begin
      @(posedge clk);
      #1;
      if (e == 5)  check_eq("b_green6", 64'(ifb.light), 64'(6'b000010));
      if (e == 6)  check_eq("b_yel", 64'(ifb.light), 64'(6'b000001));
      if (e == 10) check_eq("b_walk", 64'({ifb.walk, ifb.light}), 64'({1'b1, 6'b000000}));
      if (e == 30) check_eq("b_ph2", 64'({ifb.phase_idx, ifb.light}), 64'({2'd2, 6'b100000}));
      if (e == 45) check_eq("b_wrap", 64'({ifb.phase_idx, ifb.light}), 64'({2'd0, 6'b000010}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tlc_multi_phase.md
# tlc_multi_phase

Parametrised N-phase traffic light controller, the successor to the two-road `TLC_FSM`. It cycles the green through `N_PHASE` approaches with yellow and all-red clearance. It skips approaches with no vehicle demand. A latched pedestrian request shortens the current green to a minimum and inserts an all-red WALK interval. It sits at the top of the intersection design, driving the lamp drivers and the countdown display.

## Interface
- `N_PHASE`, 4: number of approaches/phases (2..16).
- `TW`, 6: width of the countdown timer.
- `GREEN_T`, 10: green duration, in cycles.
- `YELLOW_T`, 3: yellow duration, in cycles.
- `ALLRED_T`, 1: all-red clearance duration, in cycles.
- `PED_T`, 5: WALK duration, in cycles.
- `MIN_GREEN`, 4: minimum green when a pedestrian request is pending. Constraint: 1 ≤ `MIN_GREEN` ≤ `GREEN_T`. All durations are ≥1 and < 2^TW.
- `clk` input, 1: the only clock. All state updates on its rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `ped_req` input, 1: pedestrian push-button, sampled at posedge `clk`.
- `veh_det` input, N_PHASE: per-phase vehicle demand, bit i = approach i.
- `light` output, 2*N_PHASE: per-phase lamp code in bits [2i+1:2i]. Codes: 00 red, 01 yellow, 10 green; 11 is never driven.
- `walk` output, 1: pedestrian WALK lamp.
- `phase_idx` output, clog2(N_PHASE): index of the current/last-served phase.
- `timer_display` output, TW: cycles remaining in the current interval, minus 1.
- `ped_pending` output, 1: a pedestrian request is latched and not yet served.

## Operation
- States: GREEN, YELLOW, ALLRED, WALK.
- Every state entry loads `timer_display` with duration−1. The timer decrements by 1 each cycle.
- A state exits on the edge where `timer_display`==0. Each state therefore lasts exactly its duration in cycles.
- GREEN exits to YELLOW on either condition:
  - `timer_display`==0, or
  - `ped_pending`=1 and `timer_display` ≤ GREEN_T−MIN_GREEN. This gives a truncated green of MIN_GREEN cycles. If the request arrives later than that point, the exit is on the next edge.
- YELLOW exits to ALLRED.
- ALLRED exits to WALK if `ped_pending`=1; otherwise to GREEN of the next phase.
- WALK exits to GREEN of the next phase.
- Next phase: scan indices p+1, p+2, …, p+N_PHASE (mod N_PHASE) and take the first with `veh_det` set. If no bit is set, take p+1 mod N_PHASE (plain round-robin). p itself is reached last, so a lone demanding phase is re-served.
- `veh_det` is sampled on the edge that enters GREEN.
- `light` per state:
  - GREEN: phase p = 10, all others 00.
  - YELLOW: phase p = 01, all others 00.
  - ALLRED and WALK: all phases 00.
- `walk`=1 only in WALK.
- `ped_pending` is set on any edge with `ped_req`=1, except in WALK and on the edge entering WALK. It is cleared on the edge entering WALK. Requests during WALK are absorbed.
- All outputs are registered or decoded from registers. There is no combinational input-to-output path.
- Reset values:
  - state GREEN, `phase_idx`=0, `timer_display`=GREEN_T−1.
  - `light` = phase 0 green, others red.
  - `walk`=0, `ped_pending`=0.

## Timing
- Reset assertion takes effect immediately, with no clock needed, from any state, including mid-YELLOW and mid-WALK.
- After reset deassertion, the first decrement happens at the first posedge.
- `ped_req` asserted before edge k makes `ped_pending`=1 after edge k. The GREEN truncation decision uses the registered `ped_pending`, so it is one cycle later.
- Nominal phase period (no pedestrian request): GREEN_T+YELLOW_T+ALLRED_T = 14 cycles at defaults.
- Phase with pedestrian service: MIN_GREEN..GREEN_T, plus YELLOW_T+ALLRED_T+PED_T.
- Simultaneous `ped_req` and WALK entry: the request is dropped and `ped_pending` ends at 0.
- A `veh_det` change mid-interval has no effect until the next GREEN entry.

## Test plan
- Defaults, `veh_det`=4'b1111, no `ped_req`, rst released at 12 ns:
  - phase 0 green 10 cycles, timer counting 9→0.
  - yellow 3 cycles (2→0), then all-red 1 cycle.
  - phase 1 green starts on cycle 14; the sequence continues 0,1,2,3,0.
- `ped_req` one-cycle pulse during cycle 2 of phase 0 green:
  - green lasts 4 cycles, then yellow 3 and all-red 1.
  - WALK 5 cycles with `walk`=1 and all `light`=0; `ped_pending` drops entering WALK.
  - phase 1 green follows.
- `veh_det`=4'b1000 from reset: phase 0 → phase 3, then phase 3 is repeated every 14 cycles.
- `veh_det`=0: plain round-robin 0→1→2→3→0, same 14-cycle timing.
- `rst` pulsed asynchronously mid-YELLOW of phase 2 (between clock edges): outputs immediately return to reset values (phase 0 green, timer 9, `walk`=0, `ped_pending`=0).
- `ped_req` held high continuously:
  - every phase gets a 4-cycle green followed by WALK.
  - `ped_pending` is 0 during WALK and returns to 1 one edge after WALK exits.
- Override parameters N_PHASE=3, TW=4, GREEN_T=6, MIN_GREEN=6: a pedestrian request gives no truncation (green stays 6 cycles); the phase wrap is 2→0.
